// File: rtl/f2i_pkg.sv
// f2i_pkg: fp16 field constants, result entry type and fp16 magnitude to u16 conversion (F2I_SAT_EN selects saturation)
package f2i_pkg;
  localparam int EXP_BIAS = 15;
  localparam int MANT_W = 10;
  localparam int EXP_W = 5;
  localparam int TAG_MAX_W = 3;
  typedef struct packed {
    logic [TAG_MAX_W-1:0] tag;
    logic [15:0] data;
  } f2i_entry_t;
  function automatic logic [15:0] fp16_mag_to_u16(input logic [15:0] f);
    logic [EXP_W-1:0] e;
    logic [26:0] mid;
    logic [16:0] r;
    e = f[14:10];
    mid = 27'({1'b1, f[MANT_W-1:0]}) << (e - EXP_W'(EXP_BIAS));
    r = 17'(mid >> MANT_W);
    if (e < EXP_W'(EXP_BIAS)) return 16'h0;
`ifdef F2I_SAT_EN
    if (r[16]) return 16'hFFFF;
`endif
    return r[15:0];
  endfunction
endpackage

// File: rtl/f2i_result_fifo.sv
// f2i_result_fifo: synchronous first-word-fall-through FIFO exposing its occupancy count
module f2i_result_fifo #(
  parameter int DW = 19,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic pop_ok;
  assign empty = count == '0;
  assign pop_ok = pop & !empty;
  assign rdata = empty ? '0 : mem[rptr];
  // storage is unreset; an empty FIFO presents zero
  always_ff @(posedge clk_in)
    if (push) mem[wptr] <= wdata;
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_in)
    if (rst_in) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + PW'(push);
      rptr <= rptr + PW'(pop_ok);
      count <= count + CW'(push) - CW'(pop_ok);
    end
endmodule

// File: rtl/f2i_scheduler.sv
// f2i_scheduler: round-robin shared fp16-to-uint converter with credit-protected result FIFO (F2I_SAT_EN enables saturation)
module f2i_scheduler
  import f2i_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DEPTH = 4,
  parameter int TAGW = $clog2(NREQ)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0][15:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [15:0]           res_data,
  output logic [TAGW-1:0]       res_tag,
  output logic                  busy
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [TAGW-1:0] last, gnt_idx;
  logic found, credit_ok, fire, s1_valid, empty, tag_unused;
  logic [CW-1:0] count;
  f2i_entry_t s1, rd;
  assign credit_ok = (count + CW'(s1_valid)) < CW'(DEPTH);
  // first valid requester after last, wrapping modulo NREQ
  always_comb begin
    gnt_idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++)
      if (!found && req_valid[(int'(last) + k) % NREQ]) begin
        found = 1'b1;
        gnt_idx = TAGW'((int'(last) + k) % NREQ);
      end
  end
  assign req_ready = (found && credit_ok && !rst_in) ? (NREQ'(1) << gnt_idx) : '0;
  assign fire = |(req_valid & req_ready);
  assign res_valid = !empty;
  assign res_data = rd.data;
  assign res_tag = rd.tag[TAGW-1:0];
  assign tag_unused = |rd.tag;
  assign busy = !empty | s1_valid;
  // conversion stage and round-robin pointer
  always_ff @(posedge clk_in)
    if (rst_in) begin
      s1_valid <= 1'b0;
      s1 <= '0;
      last <= TAGW'(NREQ - 1);
    end else begin
      s1_valid <= fire;
      if (fire) begin
        s1 <= '{tag: TAG_MAX_W'(gnt_idx), data: fp16_mag_to_u16(req_data[gnt_idx])};
        last <= gnt_idx;
      end
    end
  f2i_result_fifo #(.DW($bits(f2i_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .push(s1_valid),
    .wdata(s1),
    .pop(res_ready),
    .rdata(rd),
    .empty(empty),
    .count(count)
  );
endmodule
